// File: rtl/sata_link_pkg.sv
// Shared SATA link-layer definitions: primitive encodings, transmit
// sequencer states, and the CRC32 constants/step helper.
package sata_link_pkg;

    // Link primitives as 32-bit words, K28.3/K28.5 in the low byte
    localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;
    localparam logic [31:0] PRIM_X_RDY = 32'h5757B57C;
    localparam logic [31:0] PRIM_SOF   = 32'h3737B57C;
    localparam logic [31:0] PRIM_EOF   = 32'hD5D5B57C;
    localparam logic [31:0] PRIM_WTRM  = 32'h5858B57C;
    localparam logic [31:0] PRIM_HOLD  = 32'hD5D5AA7C;
    localparam logic [31:0] PRIM_HOLDA = 32'h9595AA7C;

    // Control-character flags that accompany a word
    localparam logic [3:0] CHARISK_PRIM = 4'b0001;
    localparam logic [3:0] CHARISK_DATA = 4'b0000;

    // CRC32 generator polynomial and the seed loaded at start of frame
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] LINK_CRC_INIT = 32'h52325032;

    // Transmit sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_XRDY = 3'd1,
        ST_SOF  = 3'd2,
        ST_DATA = 3'd3,
        ST_CRC  = 3'd4,
        ST_EOF  = 3'd5,
        ST_WTRM = 3'd6
    } link_state_e;

    // Advance a CRC32 by one full dword, data bit 31 first, no inversion
    function automatic logic [31:0] crc32_step_fn(
        input logic [31:0] crc_in,
        input logic [31:0] data
    );
        logic [31:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (CRC_POLY & {32{fb}});
        end
        return c;
    endfunction

endpackage

// File: rtl/sata_crc32_step.sv
// One-dword combinational CRC32 update; shared by the TX and RX link paths.
module sata_crc32_step
    import sata_link_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data,
    output logic [31:0] crc_out
);

    // Pure combinational fold of one dword into the running CRC
    always_comb begin
        crc_out = crc32_step_fn(crc_in, data);
    end

endmodule

// File: rtl/sata_tx_frame_ctrl.sv
// SATA link-layer transmit sequencer: X_RDY, SOF, scrambled payload,
// scrambled CRC, EOF, WTRM. Owns the scrambler control strobes and the
// CRC over unscrambled payload, and handles HOLD/HOLDA flow control.
module sata_tx_frame_ctrl
    import sata_link_pkg::*;
#(
    parameter logic [31:0] CRC_INIT   = LINK_CRC_INIT,
    parameter int unsigned MAX_DWORDS = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_req,
    input  logic [31:0] up_data,
    input  logic        up_valid,
    input  logic        up_last,
    output logic        up_ready,
    input  logic        rx_r_rdy,
    input  logic        rx_hold,
    input  logic        rx_r_ok,
    input  logic        rx_r_err,
    output logic        scram_rst,
    output logic        scram_en,
    output logic [31:0] scram_din,
    input  logic [31:0] scram_dc,
    output logic [31:0] tx_data,
    output logic [3:0]  tx_charisk,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_ok
);

    // Count holds values 0..MAX_DWORDS, so one extra bit over the index width
    localparam int unsigned          CNT_W     = $clog2(MAX_DWORDS) + 1;
    localparam logic [CNT_W-1:0]     CNT_LIMIT = CNT_W'(MAX_DWORDS - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);

    link_state_e       state_q,      state_d;
    logic [31:0]       tx_data_q,    tx_data_d;
    logic [3:0]        tx_charisk_q, tx_charisk_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_ok_q,   frame_ok_d;
    logic [31:0]       crc_q,        crc_d;
    logic [CNT_W-1:0]  count_q,      count_d;
    logic              len_err_q,    len_err_d;
    logic [31:0]       crc_next_s;

    // CRC is always folded over the unscrambled upstream word
    sata_crc32_step u_crc_step (
        .crc_in  (crc_q),
        .data    (up_data),
        .crc_out (crc_next_s)
    );

    // Next-state, next-output and scrambler/handshake strobes
    always_comb begin
        state_d      = state_q;
        tx_data_d    = PRIM_SYNC;
        tx_charisk_d = CHARISK_PRIM;
        frame_done_d = 1'b0;
        frame_ok_d   = 1'b0;
        crc_d        = crc_q;
        count_d      = count_q;
        len_err_d    = len_err_q;
        up_ready     = 1'b0;
        scram_en     = 1'b0;
        scram_rst    = 1'b0;
        scram_din    = 32'h0000_0000;

        case (state_q)
            ST_IDLE: begin
                tx_data_d = PRIM_SYNC;
                if (frame_req) begin
                    state_d = ST_XRDY;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_XRDY: begin
                tx_data_d = PRIM_X_RDY;
                if (rx_r_rdy) begin
                    state_d = ST_SOF;
                end else begin
                    state_d = ST_XRDY;
                end
            end

            ST_SOF: begin
                // Reseed scrambler and CRC so every frame starts identically
                tx_data_d = PRIM_SOF;
                scram_rst = 1'b1;
                crc_d     = CRC_INIT;
                count_d   = {CNT_W{1'b0}};
                len_err_d = 1'b0;
                state_d   = ST_DATA;
            end

            ST_DATA: begin
                if (rx_hold) begin
                    // Peer asked us to pause: acknowledge, consume nothing
                    tx_data_d = PRIM_HOLDA;
                end else if (!up_valid) begin
                    // Upstream underrun: fill with HOLD, keystream frozen
                    tx_data_d = PRIM_HOLD;
                end else begin
                    up_ready     = 1'b1;
                    scram_din    = up_data;
                    scram_en     = 1'b1;
                    tx_data_d    = scram_dc;
                    tx_charisk_d = CHARISK_DATA;
                    crc_d        = crc_next_s;
                    count_d      = count_q + CNT_ONE;
                    if (up_last) begin
                        state_d = ST_CRC;
                    end else if (count_q == CNT_LIMIT) begin
                        // Frame cut short by the length limit
                        len_err_d = 1'b1;
                        state_d   = ST_CRC;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_CRC: begin
                // CRC word is scrambled with the next keystream dword
                scram_din    = crc_q;
                scram_en     = 1'b1;
                tx_data_d    = scram_dc;
                tx_charisk_d = CHARISK_DATA;
                state_d      = ST_EOF;
            end

            ST_EOF: begin
                tx_data_d = PRIM_EOF;
                state_d   = ST_WTRM;
            end

            ST_WTRM: begin
                tx_data_d = PRIM_WTRM;
                if (rx_r_ok || rx_r_err) begin
                    // R_ERR dominates when both arrive together
                    frame_done_d = 1'b1;
                    frame_ok_d   = rx_r_ok & ~rx_r_err & ~len_err_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_WTRM;
                end
            end

            default: begin
                tx_data_d = PRIM_SYNC;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State, registered PHY word and frame bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tx_data_q    <= PRIM_SYNC;
            tx_charisk_q <= CHARISK_PRIM;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            crc_q        <= CRC_INIT;
            count_q      <= {CNT_W{1'b0}};
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_charisk_q <= tx_charisk_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            crc_q        <= crc_d;
            count_q      <= count_d;
            len_err_q    <= len_err_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_charisk = tx_charisk_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
